// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Round-robin arbiter and output register for the Common Data Bus. Each
//   cycle one requesting functional unit is selected, starting the search at
//   the round-robin pointer. The winner's ROB tag and result are registered
//   and broadcast on the CDB during the following cycle.
//
// Ports
//   clk            clock
//   rst            synchronous active-high reset
//   flush          pipeline flush; suppresses any grant this cycle
//   req            per-unit request, bit i = unit i
//   req_tag        packed tags, unit i at [i*TAG_W +: TAG_W]
//   req_data       packed results, unit i at [i*DATA_W +: DATA_W]
//   grant          combinational one-hot (or zero) grant, same cycle as req
//   cdb_valid      registered broadcast valid
//   cdb_tag        registered broadcast tag
//   cdb_data       registered broadcast data
//   stat_busy      winner count (only with CDB_STATS_EN)
//   stat_conflict  count of cycles with 2+ requests and no flush
//                  (only with CDB_STATS_EN)
//
// Configuration
//   CDB_STATS_EN   define to add the statistics counters and their ports.

module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
`ifdef CDB_STATS_EN
  output logic [DATA_W-1:0]           cdb_data,
  output logic [31:0]                 stat_busy,
  output logic [31:0]                 stat_conflict
`else
  output logic [DATA_W-1:0]           cdb_data
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);
  // NUM_REQ always fits in PTR_W+1 bits, which lets the wrap compare stay
  // at a single width.
  localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  win_idx;
  logic              win_found;
  logic              winner;
  logic [PTR_W:0]    scan_sum;
  logic [PTR_W-1:0]  scan_idx;
  logic [NUM_REQ-1:0] grant_c;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;
  logic [PTR_W-1:0]  next_ptr;

  // Scan from ptr upward with wrap; the first requester found wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (scan_sum >= NUM_REQ_W) begin
        scan_sum = scan_sum - NUM_REQ_W;
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Reset and flush both squash the grant so nothing is consumed from a unit
  // whose broadcast would be discarded.
  assign winner = win_found && !flush && !rst;

  always_comb begin
    grant_c = '0;
    if (winner) begin
      grant_c[win_idx] = 1'b1;
    end
  end

  assign grant = grant_c;

  // Steer the winner's tag and data with the one-hot grant.
  always_comb begin
    win_tag  = '0;
    win_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_c[j]) begin
        win_tag  = req_tag[j*TAG_W +: TAG_W];
        win_data = req_data[j*DATA_W +: DATA_W];
      end
    end
  end

  assign next_ptr = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);

  // Tag and data only load on a win; they keep the last broadcast otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
    end else begin
      cdb_valid <= winner;
      if (winner) begin
        cdb_tag  <= win_tag;
        cdb_data <= win_data;
        ptr      <= next_ptr;
      end
    end
  end

`ifdef CDB_STATS_EN
  // Free-running counters; flush does not clear them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_busy     <= '0;
      stat_conflict <= '0;
    end else begin
      if (winner) begin
        stat_busy <= stat_busy + 32'd1;
      end
      if (!flush && ($countones(req) >= 2)) begin
        stat_conflict <= stat_conflict + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Scoreboard bench for cdb_arbiter. Each stimulus cycle computes the
//   expected grant from a reference round-robin model and queues the expected
//   CDB broadcast; the broadcast is popped and compared one cycle later.

module tb_cdb_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 5;
  localparam int DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
`ifdef CDB_STATS_EN
  logic [31:0]               stat_busy;
  logic [31:0]               stat_conflict;
`endif

  always #5 clk = ~clk;

  cdb_arbiter #(
    .NUM_REQ(NUM_REQ),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req          (req),
    .req_tag      (req_tag),
    .req_data     (req_data),
    .grant        (grant),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
`ifdef CDB_STATS_EN
    .cdb_data     (cdb_data),
    .stat_busy    (stat_busy),
    .stat_conflict(stat_conflict)
`else
    .cdb_data     (cdb_data)
`endif
  );

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } bcast_t;

  bcast_t exp_q[$];

  int checks = 0;
  int passes = 0;

  // Reference model state
  int                m_ptr;
  logic [TAG_W-1:0]  m_tag;
  logic [DATA_W-1:0] m_data;
  logic [31:0]       m_busy;
  logic [31:0]       m_conf;
  int                last_win;

  // Per-unit tag and data presented with req
  logic [TAG_W-1:0]  u_tag [NUM_REQ];
  logic [DATA_W-1:0] u_data[NUM_REQ];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end else begin
      passes++;
    end
  endtask

  // Compare the registered outputs against the oldest queued expectation.
  task automatic checkBroadcast();
    bcast_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("cdb_valid", 64'(cdb_valid), 64'(e.valid));
      checkOutput("cdb_tag",   64'(cdb_tag),   64'(e.tag));
      checkOutput("cdb_data",  64'(cdb_data),  64'(e.data));
`ifdef CDB_STATS_EN
      checkOutput("stat_busy",     64'(stat_busy),     64'(m_busy));
      checkOutput("stat_conflict", 64'(stat_conflict), 64'(m_conf));
`endif
    end
  endtask

  // One clock cycle: check last broadcast, drive inputs, check grant,
  // advance the model and queue the next expected broadcast.
  task automatic applyStimulus(input logic do_rst, input logic do_flush,
                               input logic [NUM_REQ-1:0] rq);
    bcast_t             e;
    int                 w;
    int                 idx;
    logic [NUM_REQ-1:0] eg;
    @(negedge clk);
    checkBroadcast();
    rst   = do_rst;
    flush = do_flush;
    req   = rq;
    for (int u = 0; u < NUM_REQ; u++) begin
      req_tag[u*TAG_W +: TAG_W]    = u_tag[u];
      req_data[u*DATA_W +: DATA_W] = u_data[u];
    end
    #1;
    w = -1;
    if (!do_rst && !do_flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (w < 0 && rq[idx]) w = idx;
      end
    end
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    checkOutput("grant", 64'(grant), 64'(eg));
    last_win = w;
    if (do_rst) begin
      m_ptr  = 0;
      m_tag  = '0;
      m_data = '0;
      m_busy = '0;
      m_conf = '0;
      e      = '0;
    end else begin
      if (!do_flush && $countones(rq) >= 2) m_conf = m_conf + 32'd1;
      if (w >= 0) begin
        m_busy = m_busy + 32'd1;
        m_tag  = u_tag[w];
        m_data = u_data[w];
        m_ptr  = (w + 1) % NUM_REQ;
        e      = {1'b1, m_tag, m_data};
      end else begin
        e = {1'b0, m_tag, m_data};
      end
    end
    exp_q.push_back(e);
  endtask

  initial begin
    logic [NUM_REQ-1:0] pend;
    logic               rf;
    logic               rr;

    rst      = 1'b1;
    flush    = 1'b0;
    req      = '0;
    req_tag  = '0;
    req_data = '0;
    m_ptr    = 0;
    m_tag    = '0;
    m_data   = '0;
    m_busy   = '0;
    m_conf   = '0;
    last_win = -1;
    for (int u = 0; u < NUM_REQ; u++) begin
      u_tag[u]  = '0;
      u_data[u] = '0;
    end

    // Reset with requests present must not grant; then idle.
    applyStimulus(1'b1, 1'b0, 4'b1111);
    repeat (3) applyStimulus(1'b0, 1'b0, 4'b0000);

    // Single request from unit 2.
    u_tag[2]  = 5'd7;
    u_data[2] = 32'hDEADBEEF;
    applyStimulus(1'b0, 1'b0, 4'b0100);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b0000);

    // Round-robin order from ptr=0 with all units requesting.
    for (int u = 0; u < NUM_REQ; u++) begin
      u_tag[u]  = TAG_W'(u);
      u_data[u] = $urandom;
    end
    applyStimulus(1'b1, 1'b0, 4'b0000);
    repeat (5) applyStimulus(1'b0, 1'b0, 4'b1111);

    // Wrap: unit 3 wins (ptr -> 0), then 1001 picks unit 0, then unit 3.
    applyStimulus(1'b0, 1'b0, 4'b1000);
    applyStimulus(1'b0, 1'b0, 4'b1001);
    applyStimulus(1'b0, 1'b0, 4'b1000);

    // Flush blocks the grant and keeps ptr; the held request wins next.
    applyStimulus(1'b0, 1'b1, 4'b0011);
    applyStimulus(1'b0, 1'b0, 4'b0011);
    applyStimulus(1'b0, 1'b0, 4'b0010);
    applyStimulus(1'b0, 1'b0, 4'b0000);

    // Statistics scenario.
    applyStimulus(1'b1, 1'b0, 4'b0000);
    repeat (5) applyStimulus(1'b0, 1'b0, 4'b1111);
    repeat (2) applyStimulus(1'b0, 1'b0, 4'b0001);
    applyStimulus(1'b0, 1'b0, 4'b0000);
`ifdef CDB_STATS_EN
    checkOutput("stat_busy_seven",     64'(stat_busy),     64'd7);
    checkOutput("stat_conflict_five",  64'(stat_conflict), 64'd5);
`endif
    applyStimulus(1'b1, 1'b0, 4'b1111);
    applyStimulus(1'b0, 1'b0, 4'b0000);

    // Random traffic obeying the requester contract, with flushes and one
    // mid-run reset.
    pend = '0;
    for (int c = 0; c < 80; c++) begin
      for (int u = 0; u < NUM_REQ; u++) begin
        if (!pend[u] && ($urandom_range(0, 2) == 0)) begin
          pend[u]   = 1'b1;
          u_tag[u]  = TAG_W'($urandom);
          u_data[u] = $urandom;
        end
      end
      rf = ($urandom_range(0, 7) == 0);
      rr = (c == 40);
      applyStimulus(rr, rf, pend);
      if (last_win >= 0) pend[last_win] = 1'b0;
    end

    applyStimulus(1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    checkBroadcast();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
